// File: rtl/operand_fetch_pkg.sv
// Shared widths and bundle types for the operand-fetch stage.
// Operand resolution helper is shared so both read ports resolve identically.
package of_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   typedef struct packed {
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
      logic          rd_we;
   } of_issue_t;

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [AW-1:0]   rd;
      logic            rd_we;
   } of_out_t;

   // reg_file commits at the edge, so a same-cycle writeback must be forwarded.
   function automatic logic [XLEN-1:0] resolve_operand(
      input logic [AW-1:0]   rs,
      input logic [XLEN-1:0] rdata,
      input logic            wb_we,
      input logic [AW-1:0]   wb_addr,
      input logic [XLEN-1:0] wb_data,
      input bit              x0_zero
   );
      logic is_x0;
      is_x0 = x0_zero && (rs == '0);
      if (wb_we && (wb_addr == rs) && !is_x0)
         return wb_data;
      else if (is_x0)
         return '0;
      else
         return rdata;
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle between decode, reg_file, writeback, EX and operand_fetch.
// master = surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if;
   import of_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_rs1;
   logic [AW-1:0]   in_rs2;
   logic [AW-1:0]   in_rd;
   logic            in_rd_we;
   logic [AW-1:0]   raddr1;
   logic [AW-1:0]   raddr2;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic            wb_we;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_op1;
   logic [XLEN-1:0] out_op2;
   logic [AW-1:0]   out_rd;
   logic            out_rd_we;

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
      output rdata1, rdata2, wb_we, wb_addr, wb_data, flush, out_ready,
      input  in_ready, raddr1, raddr2,
      input  out_valid, out_op1, out_op2, out_rd, out_rd_we
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
      input  rdata1, rdata2, wb_we, wb_addr, wb_data, flush, out_ready,
      output in_ready, raddr1, raddr2,
      output out_valid, out_op1, out_op2, out_rd, out_rd_we
   );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Per-register pending-writer bits with combinational hazard queries.
// A writeback releases its register in the same cycle; a concurrent set wins over clear.
module reg_scoreboard
   import of_pkg::*;
#(
   parameter bit X0_ZERO = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_addr,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          rel_en,
   input  logic [AW-1:0] rel_addr,
   input  logic [AW-1:0] q_rs1,
   input  logic [AW-1:0] q_rs2,
   input  logic [AW-1:0] q_rd,
   output logic          busy_rs1,
   output logic          busy_rs2,
   output logic          busy_rd
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             set_ok;

   assign set_ok = set_en && !(X0_ZERO && (set_addr == '0));

   assign busy_rs1 = busy[q_rs1] && !(wb_we && (wb_addr == q_rs1));
   assign busy_rs2 = busy[q_rs2] && !(wb_we && (wb_addr == q_rs2));
   assign busy_rd  = busy[q_rd]  && !(wb_we && (wb_addr == q_rd));

   always_comb begin
      busy_nxt = busy;
      if (rel_en)
         busy_nxt[rel_addr] = 1'b0;
      if (wb_we)
         busy_nxt[wb_addr] = 1'b0;
      if (set_ok)
         busy_nxt[set_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reg_file read, writeback bypass, RAW/WAW scoreboard, one-entry output buffer.
// Latency 1 cycle; in_ready drops on hazard, flush, or a held output entry.
module operand_fetch
   import of_pkg::*;
#(
   parameter bit X0_ZERO = 1'b1
) (
   input logic           clk,
   input logic           reset_n,
   operand_fetch_if.slave bus
);

   of_issue_t iss;
   of_out_t   out_q;
   of_out_t   out_d;
   logic      out_vld_q;
   logic      busy_rs1, busy_rs2, busy_rd;
   logic      hazard, ready, accept, release_en;

   assign iss = '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd, rd_we: bus.in_rd_we};

   assign bus.raddr1 = iss.rs1;
   assign bus.raddr2 = iss.rs2;

   assign out_d.op1   = resolve_operand(iss.rs1, bus.rdata1, bus.wb_we, bus.wb_addr,
                                        bus.wb_data, X0_ZERO);
   assign out_d.op2   = resolve_operand(iss.rs2, bus.rdata2, bus.wb_we, bus.wb_addr,
                                        bus.wb_data, X0_ZERO);
   assign out_d.rd    = iss.rd;
   assign out_d.rd_we = iss.rd_we;

   assign hazard     = busy_rs1 || busy_rs2 || (iss.rd_we && busy_rd);
   assign ready      = !hazard && !bus.flush && (!out_vld_q || bus.out_ready);
   assign accept     = bus.in_valid && ready;
   // A killed entry never reaches writeback, so its claim on rd must be dropped here.
   assign release_en = bus.flush && out_vld_q && out_q.rd_we;

   reg_scoreboard #(.X0_ZERO(X0_ZERO)) u_sb (
      .clk      (clk),
      .reset_n  (reset_n),
      .wb_we    (bus.wb_we),
      .wb_addr  (bus.wb_addr),
      .set_en   (accept && iss.rd_we),
      .set_addr (iss.rd),
      .rel_en   (release_en),
      .rel_addr (out_q.rd),
      .q_rs1    (iss.rs1),
      .q_rs2    (iss.rs2),
      .q_rd     (iss.rd),
      .busy_rs1 (busy_rs1),
      .busy_rs2 (busy_rs2),
      .busy_rd  (busy_rd)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else if (accept) begin
         out_vld_q <= 1'b1;
         out_q     <= out_d;
      end else if (bus.flush || bus.out_ready) begin
         out_vld_q <= 1'b0;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_vld_q;
   assign bus.out_op1   = out_q.op1;
   assign bus.out_op2   = out_q.op2;
   assign bus.out_rd    = out_q.rd;
   assign bus.out_rd_we = out_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed scenarios plus a randomized run against a reference model of the stage.
module tb_operand_fetch;
   import of_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   operand_fetch_if ifc();

   operand_fetch #(.X0_ZERO(1'b1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   always #5 clk = ~clk;

   // Reference register file: x0 is a real storage cell here, so the DUT must zero it.
   logic [XLEN-1:0] rf [NREGS];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= 32'hA500_0000 | 32'(i);
      end else if (ifc.wb_we) begin
         rf[ifc.wb_addr] <= ifc.wb_data;
      end
   end
   assign ifc.rdata1 = rf[ifc.raddr1];
   assign ifc.rdata2 = rf[ifc.raddr2];

   // Reference model: set of registers with a pending writer, and the buffered result.
   logic [NREGS-1:0] m_busy;
   logic             m_valid;
   of_out_t          m_out;

   function automatic bit m_pending(input logic [AW-1:0] r);
      if (ifc.wb_we && ifc.wb_addr == r) return 1'b0;
      return m_busy[r];
   endfunction

   function automatic bit m_ready();
      bit blocked;
      blocked = m_pending(ifc.in_rs1) || m_pending(ifc.in_rs2) ||
                (ifc.in_rd_we && m_pending(ifc.in_rd));
      if (blocked || ifc.flush) return 1'b0;
      if (m_valid && !ifc.out_ready) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [XLEN-1:0] m_operand(input logic [AW-1:0] r);
      if (r == 0) return '0;
      if (ifc.wb_we && ifc.wb_addr == r) return ifc.wb_data;
      return rf[r];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy  = '0;
         m_valid = 1'b0;
         m_out   = '0;
      end else begin
         bit               acc;
         logic [NREGS-1:0] nb;
         acc = ifc.in_valid && m_ready();
         nb  = m_busy;
         if (ifc.flush && m_valid && m_out.rd_we) nb[m_out.rd] = 1'b0;
         if (ifc.wb_we) nb[ifc.wb_addr] = 1'b0;
         if (acc && ifc.in_rd_we && ifc.in_rd != 0) nb[ifc.in_rd] = 1'b1;
         if (acc) begin
            m_valid = 1'b1;
            m_out   = '{op1: m_operand(ifc.in_rs1), op2: m_operand(ifc.in_rs2),
                        rd: ifc.in_rd, rd_we: ifc.in_rd_we};
         end else if (ifc.flush || ifc.out_ready) begin
            m_valid = 1'b0;
         end
         m_busy = nb;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifc.in_valid  = 1'b0;
      ifc.in_rs1    = '0;
      ifc.in_rs2    = '0;
      ifc.in_rd     = '0;
      ifc.in_rd_we  = 1'b0;
      ifc.wb_we     = 1'b0;
      ifc.wb_addr   = '0;
      ifc.wb_data   = '0;
      ifc.flush     = 1'b0;
      ifc.out_ready = 1'b1;
   endtask

   task automatic issue(input int rs1, input int rs2, input int rd, input bit we);
      ifc.in_valid = 1'b1;
      ifc.in_rs1   = AW'(rs1);
      ifc.in_rs2   = AW'(rs2);
      ifc.in_rd    = AW'(rd);
      ifc.in_rd_we = we;
   endtask

   task automatic wb(input int addr, input logic [XLEN-1:0] data);
      ifc.wb_we   = 1'b1;
      ifc.wb_addr = AW'(addr);
      ifc.wb_data = data;
   endtask

   task automatic test_reset();
      idle();
      #1;
      n_cmp++;
      if (ifc.out_valid !== 1'b0 || ifc.out_op1 !== '0 || ifc.out_op2 !== '0 ||
          ifc.out_rd !== '0 || ifc.out_rd_we !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: valid=%b op1=%h op2=%h rd=%0d we=%b, want all 0",
                  ifc.out_valid, ifc.out_op1, ifc.out_op2, ifc.out_rd, ifc.out_rd_we);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      issue(1, 2, 4, 1'b1);
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready);
      end
      tick();
      n_cmp++;
      if (ifc.out_valid !== 1'b1 || dut.u_sb.busy[4] !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_state: valid=%b busy4=%b want 1/1",
                  ifc.out_valid, dut.u_sb.busy[4]);
      end
      idle();
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (ifc.out_valid !== 1'b0 || dut.u_sb.busy !== '0 || ifc.out_rd !== '0) begin
         n_err++;
         $display("FAIL async_reset: valid=%b busy=%h rd=%0d want 0/0/0",
                  ifc.out_valid, dut.u_sb.busy, ifc.out_rd);
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_read();
      idle();
      wb(2, 32'h89AB_CDEF);
      tick();
      wb(3, 32'hFEDC_BA98);
      tick();
      idle();
      issue(2, 3, 5, 1'b1);
      tick();
      idle();
      n_cmp++;
      if (ifc.out_valid !== 1'b1 || ifc.out_op1 !== 32'h89AB_CDEF ||
          ifc.out_op2 !== 32'hFEDC_BA98 || ifc.out_rd !== 5) begin
         n_err++;
         $display("FAIL basic_read: v=%b op1=%h op2=%h rd=%0d want 1/89abcdef/fedcba98/5",
                  ifc.out_valid, ifc.out_op1, ifc.out_op2, ifc.out_rd);
      end
      n_cmp++;
      if (dut.u_sb.busy[5] !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy5: got %b want 1", dut.u_sb.busy[5]);
      end
   endtask

   task automatic test_raw_bypass();
      idle();
      issue(5, 2, 6, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (ifc.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL raw_stall[%0d]: in_ready=%b want 0", c, ifc.in_ready);
         end
         tick();
      end
      wb(5, 32'h1234_5678);
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL raw_release: in_ready=%b want 1", ifc.in_ready);
      end
      tick();
      idle();
      n_cmp++;
      if (ifc.out_op1 !== 32'h1234_5678 || ifc.out_op2 !== 32'h89AB_CDEF ||
          dut.u_sb.busy[5] !== 1'b0) begin
         n_err++;
         $display("FAIL raw_bypass: op1=%h op2=%h busy5=%b want 12345678/89abcdef/0",
                  ifc.out_op1, ifc.out_op2, dut.u_sb.busy[5]);
      end
   endtask

   task automatic test_waw();
      idle();
      issue(0, 0, 7, 1'b1);
      tick();
      issue(0, 0, 7, 1'b1);
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL waw_stall: in_ready=%b want 0", ifc.in_ready);
      end
      wb(7, 32'h0000_0777);
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL waw_release: in_ready=%b want 1", ifc.in_ready);
      end
      tick();
      idle();
      n_cmp++;
      if (dut.u_sb.busy[7] !== 1'b1 || ifc.out_rd !== 7 || ifc.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL waw_set_wins: busy7=%b rd=%0d v=%b want 1/7/1",
                  dut.u_sb.busy[7], ifc.out_rd, ifc.out_valid);
      end
      wb(7, 32'h0000_0778);
      tick();
      idle();
   endtask

   task automatic test_backpressure();
      idle();
      issue(2, 3, 10, 1'b0);
      tick();
      ifc.out_ready = 1'b0;
      issue(3, 2, 11, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1 || ifc.out_rd !== 10 ||
             ifc.out_op1 !== 32'h89AB_CDEF || ifc.out_op2 !== 32'hFEDC_BA98) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: rdy=%b v=%b rd=%0d op1=%h op2=%h want 0/1/10/89abcdef/fedcba98",
                     c, ifc.in_ready, ifc.out_valid, ifc.out_rd, ifc.out_op1, ifc.out_op2);
         end
         tick();
      end
      ifc.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_resume: in_ready=%b want 1", ifc.in_ready);
      end
      tick();
      idle();
      n_cmp++;
      if (ifc.out_rd !== 11 || ifc.out_op1 !== 32'hFEDC_BA98 || ifc.out_op2 !== 32'h89AB_CDEF) begin
         n_err++;
         $display("FAIL bp_load: rd=%0d op1=%h op2=%h want 11/fedcba98/89abcdef",
                  ifc.out_rd, ifc.out_op1, ifc.out_op2);
      end
   endtask

   task automatic test_x0();
      idle();
      wb(0, 32'hFFFF_FFFF);
      tick();
      issue(0, 0, 0, 1'b1);
      wb(0, 32'hFFFF_FFFF);
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL x0_ready: in_ready=%b want 1", ifc.in_ready);
      end
      tick();
      ifc.wb_we = 1'b0;
      n_cmp++;
      if (ifc.out_op1 !== '0 || ifc.out_op2 !== '0 || dut.u_sb.busy[0] !== 1'b0) begin
         n_err++;
         $display("FAIL x0_zero: op1=%h op2=%h busy0=%b want 0/0/0",
                  ifc.out_op1, ifc.out_op2, dut.u_sb.busy[0]);
      end
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL x0_never_busy: in_ready=%b want 1", ifc.in_ready);
      end
      tick();
      idle();
   endtask

   task automatic test_flush();
      idle();
      issue(2, 3, 9, 1'b1);
      tick();
      ifc.out_ready = 1'b0;
      ifc.flush     = 1'b1;
      issue(0, 0, 12, 1'b1);
      #1;
      n_cmp++;
      if (ifc.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL flush_blocks_accept: in_ready=%b want 0", ifc.in_ready);
      end
      tick();
      idle();
      n_cmp++;
      if (ifc.out_valid !== 1'b0 || dut.u_sb.busy[9] !== 1'b0 || dut.u_sb.busy[12] !== 1'b0) begin
         n_err++;
         $display("FAIL flush: v=%b busy9=%b busy12=%b want 0/0/0",
                  ifc.out_valid, dut.u_sb.busy[9], dut.u_sb.busy[12]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         ifc.in_valid  = ($urandom_range(0, 99) < 70);
         ifc.in_rs1    = AW'($urandom_range(0, 7));
         ifc.in_rs2    = AW'($urandom_range(0, 7));
         ifc.in_rd     = AW'($urandom_range(0, 7));
         ifc.in_rd_we  = ($urandom_range(0, 99) < 60);
         ifc.wb_we     = ($urandom_range(0, 99) < 40);
         ifc.wb_addr   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, NREGS - 1))
                                                     : AW'($urandom_range(0, 7));
         ifc.wb_data   = $urandom;
         ifc.flush     = ($urandom_range(0, 99) < 5);
         ifc.out_ready = ($urandom_range(0, 99) < 70);
         #1;
         n_cmp++;
         if (ifc.in_ready !== m_ready() || ifc.raddr1 !== ifc.in_rs1 || ifc.raddr2 !== ifc.in_rs2) begin
            n_err++;
            $display("FAIL rnd_ready[%0d]: rdy=%b ra1=%0d ra2=%0d want %b/%0d/%0d",
                     c, ifc.in_ready, ifc.raddr1, ifc.raddr2, m_ready(), ifc.in_rs1, ifc.in_rs2);
         end
         tick();
         n_cmp++;
         if (ifc.out_valid !== m_valid) begin
            n_err++;
            $display("FAIL rnd_valid[%0d]: got %b want %b", c, ifc.out_valid, m_valid);
         end
         if (m_valid) begin
            n_cmp++;
            if (ifc.out_op1 !== m_out.op1 || ifc.out_op2 !== m_out.op2 ||
                ifc.out_rd !== m_out.rd || ifc.out_rd_we !== m_out.rd_we) begin
               n_err++;
               $display("FAIL rnd_out[%0d]: op1=%h op2=%h rd=%0d we=%b want %h/%h/%0d/%b",
                        c, ifc.out_op1, ifc.out_op2, ifc.out_rd, ifc.out_rd_we,
                        m_out.op1, m_out.op2, m_out.rd, m_out.rd_we);
            end
         end
         n_cmp++;
         if (dut.u_sb.busy !== m_busy) begin
            n_err++;
            $display("FAIL rnd_busy[%0d]: got %h want %h", c, dut.u_sb.busy, m_busy);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_raw_bypass();
      test_waw();
      test_backpressure();
      test_x0();
      test_flush();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
